// File: rtl/inst_dispatch.sv
// rtl/inst_dispatch.sv - instruction FIFO consumer: decodes, configures and issues datapath commands
// One command in flight at a time; the next fetch waits for cmd_done.
module inst_dispatch #(
    parameter int          ADDR_W = 12,
    parameter int          LEN_W  = 16,
    parameter logic [3:0]  OP_LF  = 4'h1,
    parameter logic [3:0]  OP_LS  = 4'h2,
    parameter logic [3:0]  OP_LI  = 4'h3,
    parameter logic [3:0]  OP_DC  = 4'h4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              fifo_r_en,
    input  logic              fifo_r_accept,
    input  logic [31:0]       fifo_inst,
    output logic              cmd_valid,
    output logic [3:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    output logic [7:0]        cfg_rows,
    output logic [7:0]        cfg_cols,
    output logic [7:0]        cfg_ksize,
    output logic              cfg_valid,
    output logic              busy,
    output logic              err_opcode,
    output logic              err_cfg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [7:0]  rows_q, rows_d;
    logic [7:0]  cols_q, cols_d;
    logic [7:0]  ksize_q, ksize_d;
    logic        cfg_valid_q, cfg_valid_d;
    logic        err_opcode_q, err_opcode_d;
    logic        err_cfg_q, err_cfg_d;

    logic [3:0]  op;
    logic [7:0]  ls_rows, ls_cols, ls_k;
    logic        ls_legal;
    logic        len_zero;
    state_t      after_cmd;

    assign op       = inst_q[31:28];
    assign ls_rows  = inst_q[23:16];
    assign ls_cols  = inst_q[15:8];
    assign ls_k     = inst_q[7:0];
    assign ls_legal = (ls_k != 8'd0) && (ls_k <= ls_rows) && (ls_k <= ls_cols);
    assign len_zero = (inst_q[15:0] == 16'd0);
    assign after_cmd = enable ? FETCH : IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            inst_q       <= 32'd0;
            rows_q       <= 8'd0;
            cols_q       <= 8'd0;
            ksize_q      <= 8'd0;
            cfg_valid_q  <= 1'b0;
            err_opcode_q <= 1'b0;
            err_cfg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            ksize_q      <= ksize_d;
            cfg_valid_q  <= cfg_valid_d;
            err_opcode_q <= err_opcode_d;
            err_cfg_q    <= err_cfg_d;
        end
    end

    // Decode happens in ISSUE on the latched word, so accept-to-cmd_valid is one cycle.
    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        ksize_d      = ksize_q;
        cfg_valid_d  = cfg_valid_q;
        err_opcode_d = err_opcode_q;
        err_cfg_d    = err_cfg_q;
        fifo_r_en    = 1'b0;
        cmd_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = FETCH;
            end
            FETCH: begin
                fifo_r_en = 1'b1;
                if (fifo_r_accept) begin
                    inst_d  = fifo_inst;
                    state_d = ISSUE;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                case (op)
                    OP_LS: begin
                        if (ls_legal) begin
                            rows_d      = ls_rows;
                            cols_d      = ls_cols;
                            ksize_d     = ls_k;
                            cfg_valid_d = 1'b1;
                        end else begin
                            err_cfg_d = 1'b1;
                        end
                        state_d = after_cmd;
                    end
                    OP_LF, OP_LI: begin
                        if (len_zero) begin
                            state_d = after_cmd;
                        end else begin
                            cmd_valid = 1'b1;
                            if (cmd_ready) state_d = WAIT_DONE;
                        end
                    end
                    OP_DC: begin
                        if (cfg_valid_q) begin
                            cmd_valid = 1'b1;
                            if (cmd_ready) state_d = WAIT_DONE;
                        end else begin
                            err_cfg_d = 1'b1;
                            state_d   = after_cmd;
                        end
                    end
                    default: begin
                        err_opcode_d = 1'b1;
                        state_d      = after_cmd;
                    end
                endcase
            end
            WAIT_DONE: begin
                if (cmd_done) state_d = after_cmd;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_op     = cmd_valid ? op : 4'd0;
    assign cmd_addr   = cmd_valid ? inst_q[16 +: ADDR_W] : '0;
    assign cmd_len    = (cmd_valid && (op != OP_DC)) ? inst_q[0 +: LEN_W] : '0;
    assign cfg_rows   = rows_q;
    assign cfg_cols   = cols_q;
    assign cfg_ksize  = ksize_q;
    assign cfg_valid  = cfg_valid_q;
    assign busy       = (state_q != IDLE);
    assign err_opcode = err_opcode_q;
    assign err_cfg    = err_cfg_q;

endmodule

// File: tb/tb_inst_dispatch.sv
// tb/tb_inst_dispatch.sv - directed self-checking bench for inst_dispatch
module tb_inst_dispatch;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        fifo_r_en;
    logic        fifo_r_accept;
    logic [31:0] fifo_inst;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        cmd_ready;
    logic        cmd_done;
    logic [7:0]  cfg_rows, cfg_cols, cfg_ksize;
    logic        cfg_valid, busy, err_opcode, err_cfg;

    int checks = 0;
    int passed = 0;

    logic [31:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_count = 0;
    int hs_count = 0;
    int valid_cycles = 0;

    inst_dispatch dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_r_en(fifo_r_en), .fifo_r_accept(fifo_r_accept), .fifo_inst(fifo_inst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_ksize(cfg_ksize), .cfg_valid(cfg_valid),
        .busy(busy), .err_opcode(err_opcode), .err_cfg(err_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        fifo_r_accept = fifo_r_en && (rd_ptr != wr_ptr);
        fifo_inst     = mem[rd_ptr % 32];
    end

    always @(posedge clk) begin
        if (fifo_r_accept) begin
            rd_ptr    <= rd_ptr + 1;
            pop_count <= pop_count + 1;
        end
        if (cmd_valid) valid_cycles <= valid_cycles + 1;
        if (cmd_valid && cmd_ready) hs_count <= hs_count + 1;
    end

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 32] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic apply_reset();
        enable = 0; cmd_ready = 0; cmd_done = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic wait_cmd_valid(input int max_cycles, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (cmd_valid) begin ok = 1; break; end
        end
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({fifo_r_en, cmd_valid, cmd_op, cmd_addr, cmd_len} !== 34'd0)
            $display("FAIL reset_cmd: got %h want 0", {fifo_r_en, cmd_valid, cmd_op, cmd_addr, cmd_len});
        else passed++;
        checks++;
        if ({cfg_rows, cfg_cols, cfg_ksize, cfg_valid, busy, err_opcode, err_cfg} !== 28'd0)
            $display("FAIL reset_cfg: got %h want 0", {cfg_rows, cfg_cols, cfg_ksize, cfg_valid, busy, err_opcode, err_cfg});
        else passed++;
    endtask

    task automatic test_ls_dc();
        int p0;
        bit ok;
        p0 = pop_count;
        push(32'h2020_1003);
        push(32'h4100_0000);
        enable = 1;
        wait_cmd_valid(20, ok);
        checks++;
        if (!ok) $display("FAIL ls_dc_valid: cmd_valid never rose");
        else passed++;
        checks++;
        if ({cfg_valid, cfg_rows, cfg_cols, cfg_ksize} !== {1'b1, 8'd32, 8'd16, 8'd3})
            $display("FAIL ls_cfg: got v=%0b %0d/%0d/%0d want 1 32/16/3", cfg_valid, cfg_rows, cfg_cols, cfg_ksize);
        else passed++;
        checks++;
        if ({cmd_op, cmd_addr, cmd_len} !== {4'h4, 12'h100, 16'd0})
            $display("FAIL dc_cmd: got op=%h addr=%h len=%0d want 4 100 0", cmd_op, cmd_addr, cmd_len);
        else passed++;
        checks++;
        if (pop_count - p0 !== 2) $display("FAIL ls_dc_pops: got %0d want 2", pop_count - p0);
        else passed++;
        cmd_ready = 1;
        @(negedge clk);
        cmd_ready = 0;
        checks++;
        if ({cmd_valid, busy, fifo_r_en} !== 3'b010)
            $display("FAIL dc_after_hs: got v/busy/ren=%b want 010", {cmd_valid, busy, fifo_r_en});
        else passed++;
        repeat (4) @(negedge clk);
        cmd_done = 1;
        checks++;
        if (fifo_r_en !== 1'b0) $display("FAIL done_cycle_ren: got %b want 0", fifo_r_en);
        else passed++;
        @(negedge clk);
        cmd_done = 0;
        checks++;
        if (fifo_r_en !== 1'b1) $display("FAIL ren_after_done: got %b want 1", fifo_r_en);
        else passed++;
        enable = 0;
        wait_idle(10, ok);
        checks++;
        if (!ok) $display("FAIL ls_dc_idle: busy stuck high");
        else passed++;
    endtask

    task automatic test_stall();
        int p0, h0;
        bit ok;
        p0 = pop_count;
        h0 = hs_count;
        push(32'h1040_0009);
        push(32'h3000_0000);
        enable = 1;
        wait_cmd_valid(20, ok);
        checks++;
        if (!ok) $display("FAIL stall_valid: cmd_valid never rose");
        else passed++;
        cmd_done = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cmd_valid, cmd_op, cmd_addr, cmd_len} !== {1'b1, 4'h1, 12'h040, 16'd9})
                $display("FAIL stall_hold%0d: got v=%b op=%h addr=%h len=%0d want 1 1 040 9",
                         i, cmd_valid, cmd_op, cmd_addr, cmd_len);
            else passed++;
            @(negedge clk);
            cmd_done = 0;
        end
        cmd_ready = 1;
        @(negedge clk);
        cmd_ready = 0;
        repeat (4) @(negedge clk);
        checks++;
        if ({pop_count - p0, hs_count - h0} !== {32'd1, 32'd1})
            $display("FAIL stall_one_pop: pops=%0d hs=%0d want 1 1", pop_count - p0, hs_count - h0);
        else passed++;
        cmd_done = 1;
        @(negedge clk);
        cmd_done = 0;
        enable = 0;
        wait_idle(10, ok);
        checks++;
        if (!ok || pop_count - p0 !== 2 || hs_count - h0 !== 1)
            $display("FAIL stall_end: idle=%0b pops=%0d hs=%0d want 1 2 1", ok, pop_count - p0, hs_count - h0);
        else passed++;
    endtask

    task automatic test_cfg_err();
        int v0;
        bit ok;
        apply_reset();
        v0 = valid_cycles;
        push(32'h4030_0000);
        enable = 1;
        repeat (6) @(negedge clk);
        checks++;
        if ({err_cfg, err_opcode} !== 2'b10 || valid_cycles != v0)
            $display("FAIL dc_no_cfg: err_cfg=%b err_op=%b valid_cycles=%0d want 1 0 0",
                     err_cfg, err_opcode, valid_cycles - v0);
        else passed++;
        push(32'h2010_1014);
        repeat (6) @(negedge clk);
        checks++;
        if ({err_cfg, cfg_valid, cfg_rows, cfg_ksize} !== {1'b1, 1'b0, 8'd0, 8'd0})
            $display("FAIL ls_k_too_big: err_cfg=%b v=%b rows=%0d k=%0d want 1 0 0 0",
                     err_cfg, cfg_valid, cfg_rows, cfg_ksize);
        else passed++;
        push(32'hF000_0000);
        repeat (6) @(negedge clk);
        checks++;
        if (err_opcode !== 1'b1 || valid_cycles != v0)
            $display("FAIL bad_opcode: err_opcode=%b valid_cycles=%0d want 1 0", err_opcode, valid_cycles - v0);
        else passed++;
        enable = 0;
        wait_idle(10, ok);
    endtask

    task automatic test_empty();
        int p0;
        p0 = pop_count;
        enable = 1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_r_en !== 1'b1 || pop_count != p0)
                $display("FAIL empty_ren%0d: ren=%b pops=%0d want 1 0", i, fifo_r_en, pop_count - p0);
            else passed++;
        end
        enable = 0;
        @(negedge clk);
        checks++;
        if ({busy, fifo_r_en} !== 2'b00)
            $display("FAIL empty_drop_enable: busy/ren=%b want 00", {busy, fifo_r_en});
        else passed++;
    endtask

    task automatic test_li();
        int p0, h0;
        bit ok;
        p0 = pop_count;
        h0 = hs_count;
        push(32'h3000_0000);
        push(32'h3200_0040);
        enable = 1;
        wait_cmd_valid(20, ok);
        checks++;
        if (!ok || pop_count - p0 !== 2 || {cmd_op, cmd_addr, cmd_len} !== {4'h3, 12'h200, 16'd64})
            $display("FAIL li_cmd: ok=%0b pops=%0d op=%h addr=%h len=%0d want 1 2 3 200 64",
                     ok, pop_count - p0, cmd_op, cmd_addr, cmd_len);
        else passed++;
        cmd_ready = 1;
        @(negedge clk);
        cmd_ready = 0;
        @(negedge clk);
        cmd_done = 1;
        @(negedge clk);
        cmd_done = 0;
        enable = 0;
        wait_idle(10, ok);
        checks++;
        if (hs_count - h0 !== 1) $display("FAIL li_once: handshakes=%0d want 1", hs_count - h0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int h0;
        push(32'h1055_0004);
        enable = 1;
        wait_cmd_valid(20, ok);
        cmd_ready = 1;
        @(negedge clk);
        cmd_ready = 0;
        @(negedge clk);
        checks++;
        if (!ok || busy !== 1'b1) $display("FAIL mid_setup: ok=%0b busy=%b want 1 1", ok, busy);
        else passed++;
        rst_n = 0;
        #1;
        checks++;
        if ({busy, fifo_r_en, cmd_valid, cmd_op, cmd_addr, cmd_len} !== 35'd0)
            $display("FAIL mid_reset_out: got %h want 0", {busy, fifo_r_en, cmd_valid, cmd_op, cmd_addr, cmd_len});
        else passed++;
        @(negedge clk);
        rst_n = 1;
        enable = 0;
        h0 = hs_count;
        cmd_done = 1;
        @(negedge clk);
        cmd_done = 0;
        @(negedge clk);
        checks++;
        if ({busy, fifo_r_en, cmd_valid} !== 3'b000 || hs_count != h0)
            $display("FAIL mid_done_ignored: busy/ren/valid=%b want 000", {busy, fifo_r_en, cmd_valid});
        else passed++;
    endtask

    initial begin
        rst_n = 1; enable = 0; cmd_ready = 0; cmd_done = 0;
        @(negedge clk);
        test_reset();
        test_ls_dc();
        test_stall();
        test_li();
        test_empty();
        test_reset_mid();
        test_cfg_err();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
